// File: rtl/serial_subtractor_pkg.sv
// serial_sub_pkg: shared FSM state type and width limit for the bit-serial subtractor.
package serial_sub_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sub_state_t;
    localparam int MAX_WIDTH = 64;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result valid-ready bundle; ovf exists only with SERIAL_SUB_OVF_EN.
interface serial_subtractor_if #(parameter int WIDTH = 4);
    logic             in_valid, in_ready, bin, out_valid, out_ready, bout;
    logic [WIDTH-1:0] a, b, diff;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
    modport slave  (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, ovf);
    modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, ovf);
`else
    modport slave  (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout);
    modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor_fs.sv
// full_subtractor: one-bit combinational a - b - bin cell.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin, one bit per clock through one cell.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow flag.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sub_state_t       r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br, r_bout, w_d, w_br, w_accept, w_last;

    full_subtractor u_fs (.i_a(r_a[0]), .i_b(r_b[0]), .i_bin(r_br), .o_d(w_d), .o_bout(w_br));

    assign w_accept = bus.in_valid && r_state == S_IDLE;
    assign w_last   = r_state == S_RUN && r_cnt == CW'(WIDTH - 1);
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;

    always_comb begin
        w_next        = (w_accept) ? S_RUN :
                        (w_last) ? S_DONE :
                        (r_state == S_DONE && bus.out_ready) ? S_IDLE : r_state;
        bus.in_ready  = r_state == S_IDLE;
        bus.out_valid = r_state == S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a    <= bus.a;
                r_b    <= bus.b;
                r_br   <= bus.bin;
                r_cnt  <= '0;
                r_diff <= '0;
                r_bout <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_a    <= r_a >> 1;
                r_b    <= r_b >> 1;
                r_br   <= w_br;
                r_diff <= {w_d, r_diff[WIDTH-1:1]};
                r_cnt  <= w_last ? r_cnt : r_cnt + CW'(1);
                r_bout <= w_last ? w_br : r_bout;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb, r_b_msb, r_ovf;

    assign bus.ovf = r_ovf;

    // w_d on the last compute edge is the result MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_a_msb <= w_accept ? bus.a[WIDTH-1] : r_a_msb;
            r_b_msb <= w_accept ? bus.b[WIDTH-1] : r_b_msb;
            r_ovf   <= w_accept ? 1'b0 :
                       w_last ? (r_a_msb != r_b_msb) && (w_d != r_a_msb) : r_ovf;
        end
    end
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table vectors, stall/reset sequences and random ops with a scoreboard.
module tb_serial_subtractor;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        exp_t         e;
    } vec_t;

    logic clk = 0;
    logic rst_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t        e;
        logic [W:0]  r;
        r      = {1'b0, a} - {1'b0, b} - (W + 1)'(bin);
        e.diff = r[W-1:0];
        e.bout = r[W];
        e.ovf  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    // call at a negedge; returns just after the accepting edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input exp_t e, output int acc);
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        bus.in_valid = 1;
        for (int i = 0; i < 50 && !bus.in_ready; i++) @(negedge clk);
        chk("accept_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        sb.push_back(e);
        bus.in_valid = 0;
    endtask

    task automatic recv(input string name, input int acc, input int exp_lat, input logic keep);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
        chk({name, "_valid"}, bus.out_valid, 1);
        if (exp_lat > 0) chk({name, "_latency"}, cyc - acc + 1, exp_lat);
        chk({name, "_sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, "_diff"}, bus.diff, e.diff);
            chk({name, "_bout"}, bus.bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
            chk({name, "_ovf"}, bus.ovf, e.ovf);
`endif
        end
        bus.out_ready = 1;
        @(posedge clk);
        #1;
        if (!keep) bus.out_ready = 0;
    endtask

    initial begin
        vec_t vecs[6];
        int   acc, prev;
        exp_t e;
        logic [W-1:0] ra, rb;
        logic rbin;
        vecs[0] = '{a: 4'd9, b: 4'd3, bin: 1'b0, e: '{diff: 4'h6, bout: 1'b0, ovf: 1'b1}};
        vecs[1] = '{a: 4'd0, b: 4'd0, bin: 1'b1, e: '{diff: 4'hF, bout: 1'b1, ovf: 1'b0}};
        vecs[2] = '{a: 4'd5, b: 4'd5, bin: 1'b0, e: '{diff: 4'h0, bout: 1'b0, ovf: 1'b0}};
        vecs[3] = '{a: 4'd3, b: 4'd9, bin: 1'b0, e: '{diff: 4'hA, bout: 1'b1, ovf: 1'b1}};
        vecs[4] = '{a: 4'h7, b: 4'h8, bin: 1'b0, e: '{diff: 4'hF, bout: 1'b1, ovf: 1'b1}};
        vecs[5] = '{a: 4'd2, b: 4'd1, bin: 1'b0, e: '{diff: 4'h1, bout: 1'b0, ovf: 1'b0}};
        bus.in_valid = 0;
        bus.out_ready = 0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_bout", bus.bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", bus.ovf, 0);
`endif
        rst_n = 1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            send(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].e, acc);
            recv($sformatf("vec%0d", i), acc, W + 1, 1'b0);
        end

        // stall in S_DONE with out_ready low and a competing in_valid
        @(negedge clk);
        send(4'd3, 4'd9, 1'b0, model(4'd3, 4'd9, 1'b0), acc);
        sb.delete();
        for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
        bus.in_valid = 1;
        bus.a = 4'hF;
        bus.b = 4'h1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_diff", bus.diff, 4'hA);
            chk("stall_bout", bus.bout, 1);
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        @(posedge clk);
        #1 bus.out_ready = 0;
        @(negedge clk);
        chk("post_done_in_ready", bus.in_ready, 1);
        chk("post_done_diff_hold", bus.diff, 4'hA);
        chk("post_done_bout_hold", bus.bout, 1);

        // async reset during the second compute cycle
        send(4'hC, 4'h5, 1'b0, model(4'hC, 4'h5, 1'b0), acc);
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_diff_nonzero", bus.diff != 0, 1);
        rst_n = 0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_diff", bus.diff, 0);
        chk("midrst_bout", bus.bout, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        send(4'd6, 4'd2, 1'b0, '{diff: 4'h4, bout: 1'b0, ovf: 1'b0}, acc);
        recv("after_rst", acc, W + 1, 1'b0);

        // back-to-back random ops with out_ready held high
        bus.out_ready = 1;
        prev = -1;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            rbin = 1'($urandom_range(0, 1));
            e = model(ra, rb, rbin);
            @(negedge clk);
            send(ra, rb, rbin, e, acc);
            if (prev >= 0) chk("b2b_interval", acc - prev, W + 2);
            prev = acc;
            recv("rand", acc, W + 1, 1'b1);
        end
        bus.out_ready = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
